prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
//   Program counter for the RichieJr CPU core. Holds the address of the current
//   instruction and advances it by one on each enabled clock edge.
//   The output drives the instruction-memory address bus directly.
//   Async reset forces the reset vector. Optional parallel load supports jumps.
// PARAMETERS
//   WIDTH      4     counter / address width in bits (>=1)
//   RESET_VAL  0     value forced onto out while res is high (WIDTH bits)
//   STEP       1     increment applied per enabled edge (WIDTH bits, modulo 2^WIDTH)
// PORTS
//   clk     in   1      clock, rising-edge active
//   res     in   1      reset, asynchronous, active-high
//   en      in   1      count enable, sampled on rising clk
//   out     out  WIDTH  current program-counter value, registered
//   ld      in   1      parallel-load strobe     (only with PROG_COUNTER_LOAD_EN)
//   ld_val  in   WIDTH  value to load            (only with PROG_COUNTER_LOAD_EN)
// BEHAVIOUR
//   - Interface: one clock (clk); reset res is asynchronous and active-high.
//   - res=1: out = RESET_VAL immediately, independent of clk. Held while res is high.
//     Clock edges while res=1 have no effect.
//   - Deassertion of res is not synchronised internally. The first count occurs
//     on the first rising clk edge after res falls, if en=1 at that edge.
//   - Rising clk, res=0, en=1: out <= (out + STEP) mod 2^WIDTH. Latency is 1 edge.
//     There is no combinational path from en to out.
//   - Rising clk, res=0, en=0: out holds its value.
//   - Wrap-around: with defaults, 4'hF -> 4'h0 silently. No flag, no stall.
//   - res asserted mid-count: out jumps to RESET_VAL within the same cycle. Any
//     pending increment is discarded.
//   - X/Z on en while res=0: treat as not-enabled, out holds. This is simulation
//     guidance only; synthesis needs no special logic.
//   - Only output is out. It is never X after the first assertion of res.
// CONFIGURATION
//   - Macro PROG_COUNTER_LOAD_EN.
//   - Defined: ports ld and ld_val exist. Priority is res > ld > en.
//     Rising clk with res=0 and ld=1 gives out <= ld_val, regardless of en.
//   - Not defined: ld and ld_val are absent, and the block is a pure
//     enable-counter as above.
// TESTING
//   1. res=1, en=1, toggle clk for 2 edges -> out=0 throughout; out=0 before the
//      first edge (async).
//   2. Release res between edges with en=1. Rising edges 1,2,3 after release ->
//      out=1,2,3; no count on the edge coinciding with res=1.
//   3. Count 15 edges from 0 -> out=4'hF; next edge -> out=4'h0 (wrap).
//   4. At out=5, set en=0 for 3 edges -> out stays 5; en=1, one edge -> out=6.
//   5. At out=9, pulse res high mid-cycle (no clk edge) -> out=0 immediately;
//      release, one edge -> out=1.
//   6. (PROG_COUNTER_LOAD_EN) At out=3, ld=1, ld_val=4'hC, en=0, one edge -> out=C.
//      Next edge with ld=0, en=1 -> out=D. ld=1 together with res=1 -> out=0.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: program counter for the RichieJr CPU core.
// Holds the current instruction address and advances it by STEP on each
// enabled rising clock edge. out drives the instruction-memory address bus.
// res is an asynchronous, active-high reset that forces RESET_VAL.
// Optional parallel load (jumps) is compiled in when the macro
// PROG_COUNTER_LOAD_EN is defined. It adds the ports ld and ld_val, and the
// priority becomes res > ld > en.
module prog_counter #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter logic [WIDTH-1:0]      STEP      = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
`ifdef PROG_COUNTER_LOAD_EN
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Next-state selection. An unknown en falls through to the hold branch.
    // The addition wraps modulo 2^WIDTH, so there is no carry flag and no stall.
    always_comb begin
        count_next = count_reg;
`ifdef PROG_COUNTER_LOAD_EN
        if (ld) begin
            count_next = ld_val;
        end else if (en) begin
            count_next = count_reg + STEP;
        end
`else
        if (en) begin
            count_next = count_reg + STEP;
        end
`endif
    end

    // State register. res clears it asynchronously and discards any pending
    // increment. Deassertion of res is deliberately not synchronised here.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count_reg <= RESET_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign out = count_reg;

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed self-checking bench for prog_counter with the
// default parameters (WIDTH=4, RESET_VAL=0, STEP=1). The load scenario is
// exercised only when PROG_COUNTER_LOAD_EN is defined.
module tb_prog_counter;

    localparam int W = 4;

    logic         clk;
    logic         res;
    logic         en;
`ifdef PROG_COUNTER_LOAD_EN
    logic         ld;
    logic [W-1:0] ld_val;
`endif
    logic [W-1:0] out;

    int checks   = 0;
    int failures = 0;

    prog_counter dut (
        .clk    (clk),
        .res    (res),
        .en     (en),
`ifdef PROG_COUNTER_LOAD_EN
        .ld     (ld),
        .ld_val (ld_val),
`endif
        .out    (out)
    );

    // 10 ns clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next rising edge, then step 1 ns past it so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare out against an expected value and print one line for the check.
    task automatic check(input string tag, input logic [W-1:0] exp);
        checks++;
        assert (out === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, out, exp);
        end
        $display("check %-14s out=%h expected=%h", tag, out, exp);
    endtask

    initial begin
        // 1. Reset is asserted from time zero. out must be 0 before any edge.
        res = 1'b1;
        en  = 1'b1;
`ifdef PROG_COUNTER_LOAD_EN
        ld     = 1'b0;
        ld_val = '0;
`endif
        #1;
        check("rst_async", 4'h0);
        tick(); check("rst_edge1", 4'h0);
        tick(); check("rst_edge2", 4'h0);

        // 2. Release reset between edges. The next three edges count 1, 2, 3.
        #2 res = 1'b0;
        #1 check("rel_no_edge", 4'h0);
        tick(); check("rel_cnt1", 4'h1);
        tick(); check("rel_cnt2", 4'h2);
        tick(); check("rel_cnt3", 4'h3);

        // 3. Reset to 0, count 15 edges to F, then wrap to 0 on the next edge.
        res = 1'b1;
        #1 check("rst_mid", 4'h0);
        res = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("cnt_to_F", 4'hF);
        tick(); check("wrap_to_0", 4'h0);

        // 4. Count up to 5, hold for 3 edges with en=0, then resume.
        for (int i = 0; i < 5; i++) tick();
        check("cnt_to_5", 4'h5);
        en = 1'b0;
        tick(); check("hold1", 4'h5);
        tick(); check("hold2", 4'h5);
        tick(); check("hold3", 4'h5);
        en = 1'b1;
        #1 check("en_no_comb", 4'h5);
        tick(); check("resume_6", 4'h6);

        // An unknown en must be treated as not enabled.
        en = 1'bx;
        tick(); check("en_x_hold", 4'h6);
        en = 1'b1;

        // 5. Count to 9, pulse reset between edges, then release and count once.
        tick(); tick(); tick();
        check("cnt_to_9", 4'h9);
        #2 res = 1'b1;
        #1 check("pulse_rst", 4'h0);
        res = 1'b0;
        #1 check("pulse_rel", 4'h0);
        tick(); check("after_pulse", 4'h1);

        // Reset held across an enabled edge discards the increment.
        tick(); check("pre_rst_2", 4'h2);
        res = 1'b1;
        tick(); check("rst_over_en", 4'h0);
        res = 1'b0;
        tick(); check("post_rst_1", 4'h1);

`ifdef PROG_COUNTER_LOAD_EN
        // 6. Load has priority over en, and reset has priority over load.
        tick(); tick();
        check("cnt_to_3", 4'h3);
        en     = 1'b0;
        ld     = 1'b1;
        ld_val = 4'hC;
        tick(); check("load_C", 4'hC);
        ld = 1'b0;
        en = 1'b1;
        tick(); check("after_load_D", 4'hD);
        ld     = 1'b1;
        ld_val = 4'h7;
        tick(); check("load_over_en", 4'h7);
        res = 1'b1;
        tick(); check("rst_over_ld", 4'h0);
        res = 1'b0;
        ld  = 1'b0;
        tick(); check("post_ld_rst", 4'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
